// File: rtl/mux_pkg.sv
// Definitions shared by the serial mux/demux pair: default word width and select width.
package mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {StEmpty, StHold} out_state_e;

  // Select/index width for an n-way mux; never narrower than one bit.
  function automatic int unsigned SEL_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Mod-MOD up counter with enable, synchronous load and synchronous reset.
module wrap_counter
  import mux_pkg::*;
#(
  parameter int unsigned MOD = DEFAULT_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     load_i,
  input  logic [SEL_W(MOD)-1:0]    load_val_i,
  output logic [SEL_W(MOD)-1:0]    count_o
);

  localparam int unsigned W = SEL_W(MOD);
  localparam logic [W-1:0] LastCnt = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = (count_q == LastCnt) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Rebuilds WIDTH-bit words from a valid/ready bit stream into a single-entry
// output holding register; s_start re-aligns framing.
module serial_to_parallel
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_bit,
  input  logic                      s_valid,
  input  logic                      s_start,
  output logic                      s_ready,
  output logic [WIDTH-1:0]          p_data,
  output logic                      p_valid,
  input  logic                      p_ready,
  output logic [SEL_W(WIDTH)-1:0]   bit_idx,
  output logic                      sync_err
);

  localparam int unsigned IdxW = SEL_W(WIDTH);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(WIDTH - 1);
  localparam logic [IdxW-1:0] AfterFirst = IdxW'(1);

  out_state_e       out_st_q, out_st_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             sync_err_q, sync_err_d;

  logic            accept, start_acc, resync, complete, xfer;
  logic [IdxW-1:0] wr_idx, wr_pos;

  assign p_valid  = (out_st_q == StHold);
  assign p_data   = p_data_q;
  assign sync_err = sync_err_q;

  // Only the word-completing bit stalls; depends on registered state and p_ready only.
  assign s_ready   = !((bit_idx == LastIdx) && p_valid && !p_ready);
  assign accept    = s_valid && s_ready;
  assign start_acc = accept && s_start;
  assign resync    = start_acc && (bit_idx != '0);
  assign wr_idx    = start_acc ? '0 : bit_idx;
  assign wr_pos    = LSB_FIRST ? wr_idx : LastIdx - wr_idx;
  assign complete  = accept && (wr_idx == LastIdx);
  assign xfer      = p_valid && p_ready;

  wrap_counter #(
    .MOD (WIDTH)
  ) u_bit_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (accept),
    .load_i     (start_acc),
    .load_val_i (AfterFirst),
    .count_o    (bit_idx)
  );

  always_comb begin
    asm_d      = asm_q;
    p_data_d   = p_data_q;
    sync_err_d = resync;
    if (accept) begin
      if (resync) begin
        asm_d = '0;
      end
      asm_d[wr_pos] = s_bit;
    end
    if (complete) begin
      p_data_d = asm_d;
    end
  end

  always_comb begin
    out_st_d = out_st_q;
    unique case (out_st_q)
      StEmpty: if (complete) out_st_d = StHold;
      StHold:  if (xfer && !complete) out_st_d = StEmpty;
      default: out_st_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_st_q   <= StEmpty;
      asm_q      <= '0;
      p_data_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      out_st_q   <= out_st_d;
      asm_q      <= asm_d;
      p_data_q   <= p_data_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: three instances (W4 LSB-first, W4 MSB-first, W8)
// share one stimulus and are checked every cycle against a word-level model.
module tb_serial_to_parallel;

  logic clk = 1'b0;
  logic rst, s_bit, s_valid, s_start, p_ready;

  always #5 clk = ~clk;

  logic       rdy_a, pv_a, se_a;
  logic [3:0] pd_a;
  logic [1:0] bi_a;
  logic       rdy_b, pv_b, se_b;
  logic [3:0] pd_b;
  logic [1:0] bi_b;
  logic       rdy_c, pv_c, se_c;
  logic [7:0] pd_c;
  logic [2:0] bi_c;

  serial_to_parallel #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_start(s_start),
    .s_ready(rdy_a), .p_data(pd_a), .p_valid(pv_a), .p_ready(p_ready),
    .bit_idx(bi_a), .sync_err(se_a)
  );

  serial_to_parallel #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_start(s_start),
    .s_ready(rdy_b), .p_data(pd_b), .p_valid(pv_b), .p_ready(p_ready),
    .bit_idx(bi_b), .sync_err(se_b)
  );

  serial_to_parallel #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .s_bit(s_bit), .s_valid(s_valid), .s_start(s_start),
    .s_ready(rdy_c), .p_data(pd_c), .p_valid(pv_c), .p_ready(p_ready),
    .bit_idx(bi_c), .sync_err(se_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       rdy;
    logic       pv;
    logic       se;
    logic [2:0] idx;
    logic [7:0] pd;
  } obs_t;

  function automatic obs_t obs(input int k);
    obs_t o;
    case (k)
      0:       o = '{rdy: rdy_a, pv: pv_a, se: se_a, idx: {1'b0, bi_a}, pd: {4'b0, pd_a}};
      1:       o = '{rdy: rdy_b, pv: pv_b, se: se_b, idx: {1'b0, bi_b}, pd: {4'b0, pd_b}};
      default: o = '{rdy: rdy_c, pv: pv_c, se: se_c, idx: bi_c, pd: pd_c};
    endcase
    return o;
  endfunction

  // Reference model: bits collected in arrival order, mapped to positions on completion.
  int         m_w   [3] = '{4, 4, 8};
  bit         m_lsb [3] = '{1'b1, 1'b0, 1'b1};
  int         cnt   [3];
  logic [7:0] arr   [3];
  bit         hv    [3];
  logic [7:0] hd    [3];
  bit         err   [3];

  function automatic logic [7:0] assemble(input int k);
    logic [7:0] w = '0;
    for (int i = 0; i < m_w[k]; i++) begin
      if (m_lsb[k]) w[i] = arr[k][i];
      else          w[m_w[k] - 1 - i] = arr[k][i];
    end
    return w;
  endfunction

  function automatic bit exp_ready(input int k);
    return !(cnt[k] == m_w[k] - 1 && hv[k] && !p_ready);
  endfunction

  task automatic model_update(input int k, input bit acc);
    bit xfer = hv[k] && p_ready;
    bit comp = 1'b0;
    if (rst) begin
      cnt[k] = 0; arr[k] = '0; hv[k] = 1'b0; hd[k] = '0; err[k] = 1'b0;
      return;
    end
    err[k] = 1'b0;
    if (acc) begin
      if (s_start && cnt[k] != 0) err[k] = 1'b1;
      if (s_start) cnt[k] = 0;
      arr[k][cnt[k]] = s_bit;
      cnt[k]++;
      if (cnt[k] == m_w[k]) begin
        comp   = 1'b1;
        cnt[k] = 0;
      end
    end
    if (comp) begin
      hd[k] = assemble(k);
      hv[k] = 1'b1;
    end else if (xfer) begin
      hv[k] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: check s_ready before the edge, advance model, check registers after.
  task automatic step();
    bit acc [3];
    obs_t o;
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      chk($sformatf("s_ready[%0d]", k), 32'(o.rdy), 32'(exp_ready(k)));
      acc[k] = s_valid && exp_ready(k);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k, acc[k]);
    #1;
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      chk($sformatf("p_valid[%0d]", k), 32'(o.pv), 32'(hv[k]));
      chk($sformatf("p_data[%0d]", k), 32'(o.pd), 32'(hd[k]));
      chk($sformatf("bit_idx[%0d]", k), 32'(o.idx), 32'(cnt[k]));
      chk($sformatf("sync_err[%0d]", k), 32'(o.se), 32'(err[k]));
    end
  endtask

  task automatic drive(input bit v, input bit b, input bit st, input bit pr);
    s_valid = v; s_bit = b; s_start = st; p_ready = pr;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] words [2];
    logic [7:0] w8;
    obs_t o;
    words = '{4'b1100, 4'b1001};
    w8    = 8'h53;
    rst = 1'b0; s_bit = 1'b0; s_valid = 1'b0; s_start = 1'b0; p_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; arr[k] = '0; hv[k] = 1'b0; hd[k] = '0; err[k] = 1'b0;
    end

    do_reset();
    o = obs(0);
    chk("reset_pv", 32'(o.pv), 32'd0);
    chk("reset_idx", 32'(o.idx), 32'd0);

    // Single word with start marker, LSB first
    drive(1, 0, 1, 1); drive(1, 1, 0, 1); drive(1, 0, 0, 1); drive(1, 1, 0, 1);
    o = obs(0);
    chk("t1_pd", 32'(o.pd), 32'h0A);
    chk("t1_pv", 32'(o.pv), 32'd1);

    // Back-to-back words
    foreach (words[w]) begin
      for (int i = 0; i < 4; i++) drive(1, words[w][i], 1'b0, 1);
      o = obs(0);
      chk($sformatf("t2_pd%0d", w), 32'(o.pd), 32'(words[w]));
    end

    // Backpressure: hold 1010, accept 3 bits, stall the 4th, then release
    drive(1, 0, 0, 1); drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 1, 0, 0);
    drive(1, 1, 0, 0); drive(1, 1, 0, 0); drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    o = obs(0);
    chk("t3_hold_pd", 32'(o.pd), 32'h0A);
    chk("t3_hold_idx", 32'(o.idx), 32'd3);
    drive(1, 0, 0, 1);
    o = obs(0);
    chk("t3_reload_pd", 32'(o.pd), 32'h07);
    chk("t3_reload_pv", 32'(o.pv), 32'd1);

    // Resync after two bits
    drive(1, 1, 0, 1); drive(1, 1, 0, 1);
    drive(1, 1, 1, 1);
    o = obs(0);
    chk("t4_err_on", 32'(o.se), 32'd1);
    drive(1, 0, 0, 1);
    o = obs(0);
    chk("t4_err_off", 32'(o.se), 32'd0);
    drive(1, 0, 0, 1); drive(1, 1, 0, 1);
    o = obs(0);
    chk("t4_pd", 32'(o.pd), 32'h09);

    // Reset mid-word
    drive(1, 1, 0, 1); drive(1, 1, 0, 1);
    do_reset();
    o = obs(0);
    chk("t5_pv", 32'(o.pv), 32'd0);
    chk("t5_idx", 32'(o.idx), 32'd0);
    drive(1, 0, 0, 1); drive(1, 1, 0, 1); drive(1, 1, 0, 1); drive(1, 0, 0, 1);
    o = obs(0);
    chk("t5_pd", 32'(o.pd), 32'h06);

    // MSB-first instance, then 8-bit instance
    do_reset();
    drive(1, 1, 0, 1); drive(1, 0, 0, 1); drive(1, 1, 0, 1); drive(1, 0, 0, 1);
    o = obs(1);
    chk("t6_msb_pd", 32'(o.pd), 32'h0A);
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, (i == 0 || i == 1 || i == 4 || i == 6), 1'b0, 1);
    o = obs(2);
    chk("t6_w8_pd", 32'(o.pd), 32'(w8));

    // Randomized traffic with occasional resets and start markers
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
